// File: rtl/pipe_pkg.sv
// Shared pipeline package: control-bit and lane index constants plus the
// default widths used by every stage-boundary register of the 5-stage core.
// No ports; imported by pipereg_stage_hs and pipereg_sat_counter.
package pipe_pkg;
  // EX/MEM control vector bit positions
  localparam int CTRL_REG_WRITE       = 0;
  localparam int CTRL_MEM_READ        = 1;
  localparam int CTRL_MEM_WRITE       = 2;
  localparam int CTRL_DMEM_TO_REG_LSB = 3;
  localparam int CTRL_DMEM_TO_REG_MSB = 4;
  localparam int CTRL_PC_SELECT       = 5;

  // data lane indices
  localparam int LANE_PCSRC  = 0;
  localparam int LANE_PC_NEW = 1;
  localparam int LANE_ALU    = 2;
  localparam int LANE_RD2    = 3;

  // default widths
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_CTRL_W    = 8;
  localparam int DEF_CNT_W     = 16;
endpackage

// File: rtl/pipereg_sat_counter.sv
// Saturating up-counter used for bubble accounting.
// Ports: clk (clock), clear (sync clear, wins over inc), inc (count enable),
//        count (current value; sticks at all-ones, never wraps).
module pipereg_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (clear)                  count <= '0;
    else if (inc && ~&count)    count <= count + 1'b1;
  end
endmodule

// File: rtl/pipereg_stage_hs.sv
// Handshaked pipeline register for any stage boundary: a control vector plus
// NUM_LANES data lanes, with stall by backpressure, flush, reset-cleared
// control and a saturating bubble counter.
// Ports: clk_i, reset_i (sync, active high); upstream valid_i/ready_o/ctrl_i/
//        data_i; flush_i; downstream valid_o/ready_i/ctrl_o/data_o;
//        bubble_cnt_o (cycles with valid_o=0 since reset).
// Build option: define PIPEREG_SKID_EN to add a skid entry so ready_o comes
// straight from a flop instead of from ready_i.
module pipereg_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [CTRL_W-1:0]           ctrl_i,
  input  logic [NUM_LANES*DATA_W-1:0] data_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [CTRL_W-1:0]           ctrl_o,
  output logic [NUM_LANES*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]            bubble_cnt_o
);
  localparam int DW = NUM_LANES*DATA_W;

  logic          valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DW-1:0] data_q;
  logic          accept;

  assign accept = valid_i & ready_o;

`ifdef PIPEREG_SKID_EN
  logic              skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DW-1:0]     skid_data_q;
  logic              main_free;

  assign ready_o   = ~skid_valid_q;
  // main entry is empty or leaves this edge
  assign main_free = ~valid_q | ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // ready_o is low here, so no accept can race the skid move
        valid_q      <= 1'b1;
        ctrl_q       <= skid_ctrl_q;
        data_q       <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_i;
        data_q  <= data_i;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (accept) begin
      // main stalled: park the input in the (empty) skid entry
      skid_valid_q <= 1'b1;
      skid_ctrl_q  <= ctrl_i;
      skid_data_q  <= data_i;
    end
  end
`else
  logic drain;

  assign ready_o = ~valid_q | ready_i;
  assign drain   = valid_q & ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign valid_o = valid_q;
  // bubbles never present live control bits downstream
  assign ctrl_o  = valid_q ? ctrl_q : '0;
  assign data_o  = data_q;

  pipereg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk_i),
    .clear (reset_i),
    .inc   (~valid_q),
    .count (bubble_cnt_o)
  );
endmodule
